// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: one frame per byte, pop-to-send latency 1 cycle, sticky overflow.
// Pushes are never back-pressured; a full FIFO drops the byte unless a pop frees a slot in the same cycle.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 262143
) (
  input  logic                  fclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  busy,
  output logic                  tx_err,
  output logic                  uart_send,
  output logic [7:0]            uart_data,
  input  logic [3:0]            uart_sta,
  input  logic                  uart_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [17:0]      TMR_LAST = 18'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } state_t;

  logic [7:0]       mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             tx_err_q, tx_err_d;
  logic             send_q, send_d;
  logic [7:0]       data_q, data_d;
  logic [17:0]      timer_q, timer_d;
  logic             push;
  logic             pop;

  always_comb begin
    // A pop frees a slot, so a push into a full FIFO still lands in that cycle.
    pop  = (state_q == S_IDLE) && !empty_q;
    push = wr_en && (!full_q || pop);

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);

    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end else if (wr_en && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    send_d   = send_q;
    data_d   = data_q;
    tx_err_d = 1'b0;
    timer_d  = timer_q + 18'd1;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          send_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (timer_q == TMR_LAST) begin
          send_d   = 1'b0;
          tx_err_d = 1'b1;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else if (uart_sta != 4'd0) begin
          send_d  = 1'b0;
          timer_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Frame must be fully over (sta back to 0) before the next byte is offered.
        if (timer_q == TMR_LAST) begin
          tx_err_d = 1'b1;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else if ((uart_sta == 4'd0) && uart_done) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        send_d  = 1'b0;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      tx_err_q   <= 1'b0;
      send_q     <= 1'b0;
      data_q     <= 8'h00;
      timer_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
      tx_err_q   <= tx_err_d;
      send_q     <= send_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
    end
  end

  // Storage is not reset; level gates every read.
  always_ff @(posedge fclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign tx_err    = tx_err_q;
  assign uart_send = send_q;
  assign uart_data = data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural transmitter (start 3 cycles after send, 40-cycle frame).
module tb_uart_tx_queue;

  logic       fclk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, busy, tx_err, uart_send;
  logic [4:0] level;
  logic [7:0] uart_data;
  logic [3:0] uart_sta = 4'd0;
  logic       uart_done = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  bit         model_en = 1'b0;
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_queue #(.DEPTH_LOG2(4), .TIMEOUT(64)) dut (
    .fclk(fclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .clr_ovf(clr_ovf), .busy(busy), .tx_err(tx_err),
    .uart_send(uart_send), .uart_data(uart_data),
    .uart_sta(uart_sta), .uart_done(uart_done)
  );

  always #5 fclk = ~fclk;

  // Transmitter model: sta goes 1 on the third edge that sees send, back to 0 with done 40 cycles later.
  always @(posedge fclk or negedge rst) begin
    if (!rst) begin
      m_act <= 1'b0; m_cnt <= 0; uart_sta <= 4'd0; uart_done <= 1'b0;
    end else begin
      uart_done <= 1'b0;
      if (m_act) begin
        if (m_cnt == 39) begin
          m_act <= 1'b0; m_cnt <= 0; uart_sta <= 4'd0; uart_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (model_en && uart_send) begin
        if (m_cnt == 2) begin
          m_act <= 1'b1; m_cnt <= 0; uart_sta <= 4'd1; rx_q.push_back(uart_data);
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_cnt <= 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge fclk);
    rst = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; model_en = 1'b0;
    @(negedge fclk);
    rst = 1'b1;
    rx_q.delete(); exp_q.delete();
    @(negedge fclk);
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    int t = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && t < max_cyc) begin
      @(negedge fclk); t++;
    end
    ok = (t < max_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge fclk);
    n_tests++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_tests++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_tests++; if (level !== 5'd0)     begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (tx_err !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_err got %b exp 0", tx_err); end
    n_tests++; if (uart_send !== 1'b0) begin n_fail++; $display("FAIL reset_send got %b exp 0", uart_send); end
    n_tests++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", uart_data); end
    rst = 1'b1;
    @(negedge fclk);
  endtask

  task automatic test_basic_send();
    int hi = 0;
    int bw = 0;
    bit ok;
    do_reset();
    model_en = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge fclk); wr_en = 1'b0;
    n_tests++; if (level !== 5'd1)     begin n_fail++; $display("FAIL basic_level1 got %0d exp 1", level); end
    n_tests++; if (uart_send !== 1'b0) begin n_fail++; $display("FAIL basic_send_early got %b exp 0", uart_send); end
    @(negedge fclk);
    n_tests++; if (uart_send !== 1'b1)  begin n_fail++; $display("FAIL basic_send got %b exp 1", uart_send); end
    n_tests++; if (uart_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h exp a5", uart_data); end
    n_tests++; if (busy !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL basic_busy_empty got %b%b exp 11", busy, empty); end
    while (uart_send === 1'b1 && hi < 200) begin hi++; @(negedge fclk); end
    n_tests++; if (hi != 4) begin n_fail++; $display("FAIL basic_send_len got %0d exp 4", hi); end
    n_tests++; if (uart_sta !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_state sta %0d busy %b exp 1 1", uart_sta, busy); end
    while (busy === 1'b1 && bw < 200) begin bw++; @(negedge fclk); end
    n_tests++; if (bw != 40) begin n_fail++; $display("FAIL basic_busy_len got %0d exp 40", bw); end
    wait_drain(10, ok);
    n_tests++; if (!ok || empty !== 1'b1) begin n_fail++; $display("FAIL basic_idle got ok=%b empty=%b exp 1 1", ok, empty); end
    n_tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_rx got size %0d exp 1 byte a5", rx_q.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    int bad = 0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge fclk); wr_en = 1'b0;
    repeat (2) @(negedge fclk);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge fclk);
    end
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL ovf_fill got level %0d full %b exp 16 1", level, full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge fclk); wr_en = 1'b0;
    n_tests++; if (overflow !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_set got ovf %b level %0d exp 1 16", overflow, level); end
    wr_en = 1'b1; wr_data = 8'hFE; clr_ovf = 1'b1;
    @(negedge fclk); wr_en = 1'b0; clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_priority got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 8'hFD;
    @(negedge fclk); wr_en = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_reset got %b exp 1", overflow); end
    model_en = 1'b1;
    wait_drain(2000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_drain got timeout exp idle"); end
    if (rx_q.size() != 17) bad++;
    else begin
      if (rx_q[0] !== 8'h55) bad++;
      for (int i = 0; i < 16; i++) if (rx_q[i+1] !== 8'(i)) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ovf_order got %0d bytes %0d wrong exp 17 bytes 55,00..0f", rx_q.size(), bad); end
    n_tests++; if (overflow !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got ovf %b full %b exp 1 0", overflow, full); end
    clr_ovf = 1'b1;
    @(negedge fclk); clr_ovf = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_push_pop();
    bit ok;
    int bad = 0;
    do_reset();
    model_en = 1'b1;
    wr_en = 1'b1; wr_data = 8'h40;
    @(negedge fclk);
    n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL pp_level_a got %0d exp 1", level); end
    wr_data = 8'h41;
    @(negedge fclk);
    n_tests++; if (level !== 5'd1 || uart_send !== 1'b1) begin n_fail++; $display("FAIL pp_same_cycle got level %0d send %b exp 1 1", level, uart_send); end
    wr_data = 8'h42;
    @(negedge fclk); wr_en = 1'b0;
    n_tests++; if (level !== 5'd2) begin n_fail++; $display("FAIL pp_level_b got %0d exp 2", level); end
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      while (busy !== 1'b0 && t < 200) begin @(negedge fclk); t++; end
      wr_en = 1'b1; wr_data = 8'(8'h43 + k);
      @(negedge fclk); wr_en = 1'b0;
      n_tests++; if (t >= 200 || level !== 5'd2) begin n_fail++; $display("FAIL pp_busy_push%0d got level %0d wait %0d exp 2", k, level, t); end
    end
    wait_drain(1000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL pp_drain got timeout exp idle"); end
    if (rx_q.size() != 7) bad++;
    else for (int i = 0; i < 7; i++) if (rx_q[i] !== 8'(8'h40 + i)) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL pp_order got %0d bytes %0d wrong exp 40..46", rx_q.size(), bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    int hi = 0;
    int t = 0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge fclk); wr_data = 8'h3D;
    @(negedge fclk); wr_en = 1'b0;
    while (uart_send !== 1'b1 && t < 10) begin @(negedge fclk); t++; end
    while (uart_send === 1'b1 && tx_err === 1'b0 && hi < 300) begin hi++; @(negedge fclk); end
    n_tests++; if (hi != 64) begin n_fail++; $display("FAIL tmo_issue_len got %0d exp 64", hi); end
    n_tests++; if (tx_err !== 1'b1 || uart_send !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_abort got err %b send %b busy %b exp 1 0 0", tx_err, uart_send, busy); end
    @(negedge fclk);
    n_tests++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse got %b exp 0", tx_err); end
    n_tests++; if (uart_send !== 1'b1 || uart_data !== 8'h3D) begin n_fail++; $display("FAIL tmo_next got send %b data %h exp 1 3d", uart_send, uart_data); end
    model_en = 1'b1;
    wait_drain(200, ok);
    n_tests++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h3D) begin n_fail++; $display("FAIL tmo_rx got ok %b size %0d exp 1 byte 3d", ok, rx_q.size()); end
  endtask

  task automatic test_reset_busy();
    int t = 0;
    int seen = 0;
    do_reset();
    model_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      @(negedge fclk);
    end
    wr_en = 1'b0;
    while (!(busy === 1'b1 && uart_send === 1'b0) && t < 100) begin @(negedge fclk); t++; end
    n_tests++; if (t >= 100 || level !== 5'd5) begin n_fail++; $display("FAIL rb_queued got level %0d wait %0d exp 5", level, t); end
    rst = 1'b0;
    #1;
    n_tests++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rb_async_fifo got level %0d empty %b full %b exp 0 1 0", level, empty, full); end
    n_tests++; if (uart_send !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rb_async_seq got send %b busy %b exp 0 0", uart_send, busy); end
    @(negedge fclk);
    rst = 1'b1; rx_q.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge fclk);
      if (uart_send === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++; if (seen != 0 || rx_q.size() != 0) begin n_fail++; $display("FAIL rb_no_send got %0d active cycles %0d frames exp 0 0", seen, rx_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i); exp_q.push_back(8'(8'h80 + i));
      @(negedge fclk);
    end
    wr_en = 1'b0;
    n_tests++; if (level !== 5'd15) begin n_fail++; $display("FAIL wrap_fill got %0d exp 15", level); end
    model_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int t = 0;
      if (k > 0) while (busy !== 1'b0 && t < 200) begin @(negedge fclk); t++; end
      wr_en = 1'b1; wr_data = 8'(8'h90 + k); exp_q.push_back(8'(8'h90 + k));
      @(negedge fclk); wr_en = 1'b0;
      n_tests++; if (t >= 200 || level !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL wrap_push%0d got level %0d full %b exp 16 1", k, level, full); end
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_no_ovf got %b exp 0", overflow); end
    wait_drain(2500, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_drain got timeout exp idle"); end
    if (rx_q.size() != exp_q.size()) bad++;
    else for (int i = 0; i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap_order got %0d bytes %0d wrong exp %0d in order", rx_q.size(), bad, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_overflow();
    test_push_pop();
    test_timeout();
    test_reset_busy();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
